// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor: controller states and the
// two-bit status codes reported to software.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_PASS    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_PASS    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/run_monitor_chan.sv
// One monitored channel: a sticky "done seen" flag plus the ALU result
// captured on the first RUN cycle that the channel reports done.
module run_monitor_chan
    import run_monitor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            sample_i,
    input  logic            done_i,
    input  logic [XLEN-1:0] alures_i,
    output logic            flag_o,
    output logic [XLEN-1:0] result_o
);

    logic            flag_q;
    logic [XLEN-1:0] result_q;

    // Sticky flag and first-done capture; cleared when a new run launches.
    // NOTE: result_q is a plain register, not a memory, so it takes the async
    // reset; a reset abort must leave no partial result behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, independent of statement order.
            flag_q   <= 1'b0;
            result_q <= '0;
        end else if (clear_i) begin
            flag_q   <= 1'b0;
            result_q <= '0;
        end else if (sample_i && done_i && !flag_q) begin
            flag_q   <= 1'b1;
            result_q <= alures_i;
        end
    end

    assign flag_o   = flag_q;
    assign result_o = result_q;

endmodule

// File: rtl/run_monitor.sv
// Run monitor: holds the cores in reset after start, then counts run
// cycles until every channel reports done (PASS) or MAX_CYCLES elapse
// (TIMEOUT). Optional feature macro RUN_MONITOR_SIG_EN adds a rolling
// signature over next-PC and ALU result of the still-running channels.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NCH        = 2,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 1024,
    parameter int CW         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                core_rst,
    input  logic [NCH*XLEN-1:0] core_nxtpc,
    input  logic [NCH*XLEN-1:0] core_alures,
    input  logic [NCH-1:0]      core_done,
    output logic                busy,
    output logic [1:0]          status,
    output logic [CW-1:0]       cycles,
    output logic [NCH*XLEN-1:0] result
`ifdef RUN_MONITOR_SIG_EN
    ,
    output logic [XLEN-1:0]     sig
`endif
);

    localparam int            HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_CYCLES);

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]   cycles_q, cycles_d, cycles_inc;
    logic [NCH-1:0]  flag;
    logic            launch, in_run, all_set;

    assign in_run     = (state_q == S_RUN);
    assign launch     = start && (state_q inside {S_IDLE, S_PASS, S_TIMEOUT});
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
    // Done arriving this cycle counts toward completion immediately.
    assign all_set    = &(flag | core_done);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        run_monitor_chan #(.XLEN(XLEN)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (launch),
            .sample_i (in_run),
            .done_i   (core_done[i]),
            .alures_i (core_alures[i*XLEN +: XLEN]),
            .flag_o   (flag[i]),
            .result_o (result[i*XLEN +: XLEN])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; PASS takes priority over TIMEOUT.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_PASS, S_TIMEOUT: if (start) state_d = S_HOLD;
            S_HOLD:                    if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
            S_RUN: begin
                if (all_set)                    state_d = S_PASS;
                else if (cycles_inc == MAX_CNT) state_d = S_TIMEOUT;
            end
            default:                   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        busy     = (state_q == S_HOLD) || (state_q == S_RUN);
        core_rst = (state_q == S_IDLE) || (state_q == S_HOLD);
        unique case (state_q)
            S_HOLD, S_RUN: status = ST_RUN;
            S_PASS:        status = ST_PASS;
            S_TIMEOUT:     status = ST_TIMEOUT;
            default:       status = ST_IDLE;
        endcase
    end

    // Hold-phase and run-phase counter next values.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        cycles_d   = cycles_q;
        if (launch) begin
            hold_cnt_d = '0;
            cycles_d   = '0;
        end else if (state_q == S_HOLD) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (in_run) begin
            cycles_d = cycles_inc;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
            cycles_q   <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            cycles_q   <= cycles_d;
        end
    end

    assign cycles = cycles_q;

`ifdef RUN_MONITOR_SIG_EN
    logic [XLEN-1:0] sig_q, sig_d, sig_mix;

    // Contribution of channels that have not yet reported done.
    always_comb begin
        sig_mix = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!flag[i]) sig_mix = sig_mix ^ core_nxtpc[i*XLEN +: XLEN] ^ core_alures[i*XLEN +: XLEN];
        end
    end

    // Signature next value: rotate left by one and fold in the mix.
    always_comb begin
        sig_d = sig_q;
        if (launch)      sig_d = '0;
        else if (in_run) sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ sig_mix;
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sig_q <= '0;
        else      sig_q <= sig_d;
    end

    assign sig = sig_q;
`else
    logic unused_nxtpc;
    assign unused_nxtpc = ^core_nxtpc;
`endif

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of each core's PC and ALU result.
REQ-002 SHALL have parameter NCH, default 2: number of monitored CPU channels.
REQ-003 SHALL have parameter RST_CYCLES, default 2: cycles core reset is held after start.
REQ-004 SHALL have parameter MAX_CYCLES, default 1024: run-phase timeout in cycles.
REQ-005 SHALL have parameter CW, default 16: cycle counter width, with CW >= clog2(MAX_CYCLES+1).
REQ-006 SHALL have port clk  in  1: single clock, all state updates on rising edge.
REQ-007 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-008 SHALL have port start  in  1: one-cycle pulse that launches a run.
REQ-009 SHALL have port core_rst  out  1: active-high reset driven to all cores.
REQ-010 SHALL have port core_nxtpc  in  NCH*XLEN: per-channel next PC, channel i at bits [i*XLEN +: XLEN].
REQ-011 SHALL have port core_alures  in  NCH*XLEN: per-channel ALU result, same packing.
REQ-012 SHALL have port core_done  in  NCH: per-channel halt flag.
REQ-013 SHALL have port busy  out  1: high in HOLD or RUN.
REQ-014 SHALL have port status  out  2: 00 idle, 01 running, 10 pass, 11 timeout.
REQ-015 SHALL have port cycles  out  CW: run-phase cycle count.
REQ-016 SHALL have port result  out  NCH*XLEN: per-channel alures captured on that channel's first done.

Function
REQ-017 SHALL implement FSM IDLE -> HOLD -> RUN -> {PASS | TIMEOUT}; PASS and TIMEOUT return to HOLD on start.
REQ-018 SHALL, in IDLE/PASS/TIMEOUT, ignore core_done and hold all outputs stable.
REQ-019 SHALL, on start in IDLE/PASS/TIMEOUT, enter HOLD, clear cycles, result, sticky done flags and signature.
REQ-020 SHALL assert core_rst in every HOLD cycle and for exactly RST_CYCLES cycles, then enter RUN.
REQ-021 SHALL increment cycles by 1 each RUN cycle, saturating at 2^CW-1.
REQ-022 SHALL set sticky flag i and capture core_alures[i] into result[i] on the first RUN cycle core_done[i] is high; later values ignored.
REQ-023 SHALL enter PASS the cycle after all sticky flags (including same-cycle arrivals) are set.
REQ-024 SHALL enter TIMEOUT when cycles equals MAX_CYCLES and not all flags set; PASS wins if both hold in the same cycle.
REQ-025 SHALL ignore start while in HOLD or RUN.
REQ-026 SHALL treat core_done high during HOLD as not-done.

Reset
REQ-027 SHALL, on rst low, asynchronously enter IDLE with core_rst=1, busy=0, status=00, cycles=0, result=0, sig=0, flags=0.
REQ-028 SHALL, on rst low mid-run, abort the run immediately; no partial result retained.
REQ-029 SHALL, after rst release, keep core_rst=1 until a start-initiated HOLD completes.

Configuration
REQ-030 SHALL support macro RUN_MONITOR_SIG_EN.
REQ-031 SHALL, with RUN_MONITOR_SIG_EN defined, add port sig out XLEN: each RUN cycle sig <= rotl(sig,1) ^ XOR over channels of (core_nxtpc[i] ^ core_alures[i]) for channels with flag clear; frozen in PASS/TIMEOUT.
REQ-032 SHALL, without RUN_MONITOR_SIG_EN, have no sig port and no signature logic.

Structure
REQ-033 SHALL place FSM state enum and status encodings (ST_IDLE, ST_RUN, ST_PASS, ST_TIMEOUT) in shared package run_monitor_pkg.
REQ-034 SHALL use one sub-module run_monitor_chan, instantiated NCH times, holding sticky flag and result capture.

Verification
REQ-035 SHALL cover: NCH=2, start, core_done=2'b11 at run cycle 5 -> core_rst high 2 cycles, status=10, cycles=6.
REQ-036 SHALL cover: done[0] at cycle 3 (alures=0x11), done[1] at cycle 9 (alures=0x22) -> result={0x22,0x11}, PASS cycle 10.
REQ-037 SHALL cover: MAX_CYCLES=8, no done -> status=11, cycles=8, busy=0.
REQ-038 SHALL cover: rst low during RUN cycle 4 -> status=00, result=0, core_rst=1 asynchronously.
REQ-039 SHALL cover: start re-pulsed during RUN and again after PASS -> first ignored, second restarts with cycles=0.
REQ-040 SHALL cover: RUN_MONITOR_SIG_EN, NCH=1, nxtpc=4, alures=1 for 2 cycles then done -> sig=0x00000005 then 0x0000000F.
